// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment debug display controller:
//   - conversion FSM state encoding (IDLE, LOAD, SHIFT, DONE)
//   - active-low {g,f,e,d,c,b,a} segment codes for digits 0-9 and blank
//   - width of the binary value being displayed
//   - helpers: segment decode and the double-dabble "add 3" correction
// ---------------------------------------------------------------------------
package ssd_pkg;

   localparam int VAL_W = 13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } conv_state_e;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // BCD nibble to active-low segment pattern; non-decimal codes blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Adds 3 to every nibble >= 5 so the following left shift carries
   // correctly into the next decimal digit.
   function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
      logic [15:0] res;
      res = bcd;
      for (int i = 0; i < 4; i++) begin
         if (res[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = res[4*i +: 4] + 4'd3;
         end else begin
            res[4*i +: 4] = res[4*i +: 4];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// ---------------------------------------------------------------------------
// ssd_bin2bcd
// Sequential double-dabble converter: 13-bit unsigned -> 4 BCD digits.
// A request (start_i or abort_i) is remembered in a pending flag and
// serviced from IDLE. abort_i while LOAD/SHIFT restarts the conversion so
// the freshly selected value is sampled; the partial result is dropped.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start_i     conversion request (scan frame wrap)
//   abort_i     selection changed: restart / request conversion
//   value_i     13-bit value sampled in LOAD
//   bcd_o       BCD working register, valid while done_o is high
//   done_o      high for the single DONE cycle
//   busy_o      registered, high from LOAD until DONE completes
// ---------------------------------------------------------------------------
module ssd_bin2bcd
   import ssd_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [VAL_W-1:0]  value_i,
   output logic [15:0]       bcd_o,
   output logic              done_o,
   output logic              busy_o
);

   conv_state_e      state_q, state_d;
   logic             pending_q, pending_d;
   logic [VAL_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [15:0]      adj_s;

   assign adj_s = bcd_adjust(bcd_q);

   // Conversion state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 1'b1;
         bin_q     <= {VAL_W{1'b0}};
         bcd_q     <= 16'd0;
         cnt_q     <= 4'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state logic for the double-dabble sequencer.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | start_i | abort_i;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            if (pending_q) begin
               pending_d = 1'b0;
               state_d   = LOAD;
            end else begin
               state_d   = IDLE;
            end
         end
         LOAD: begin
            bin_d   = value_i;
            bcd_d   = 16'd0;
            cnt_d   = 4'd0;
            busy_d  = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            bcd_d = {adj_s[14:0], bin_q[VAL_W-1]};
            bin_d = {bin_q[VAL_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(VAL_W - 1)) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A new selection mid-conversion restarts; its request is consumed here.
      if (abort_i && ((state_q == LOAD) || (state_q == SHIFT))) begin
         state_d   = LOAD;
         pending_d = 1'b0;
      end else begin
         state_d   = state_d;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = (state_q == DONE);
   assign busy_o = busy_q;

endmodule

// File: rtl/ssd_scan_controller.sv
// ---------------------------------------------------------------------------
// ssd_scan_controller
// Seven-segment debug display sequencer: steps the debug selection code on
// button presses, converts the selected 13-bit value to BCD and scans the
// four digits onto a common-anode display with leading-zero blanking.
// Optional feature macro: SSD_DEBOUNCE_EN (button debounce counter).
// Parameters: DIGIT_PERIOD (cycles per digit), DEBOUNCE_CYCLES, NUM_SEL.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   btn_next    raw pushbutton, each accepted press advances ssd_sel
//   ssd_value   value returned by the debug selector for ssd_sel
//   ssd_sel     registered selection code (0..NUM_SEL-1)
//   anode       active-low digit enables, bit 0 = least significant digit
//   cathode     active-low segments {g,f,e,d,c,b,a}
//   busy        conversion in flight
// ---------------------------------------------------------------------------
module ssd_scan_controller
   import ssd_pkg::*;
#(
   parameter int DIGIT_PERIOD    = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int NUM_SEL         = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn_next,
   input  logic [VAL_W-1:0]  ssd_value,
   output logic [3:0]        ssd_sel,
   output logic [3:0]        anode,
   output logic [6:0]        cathode,
   output logic              busy
);

   localparam int              DIV_W    = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_PERIOD - 1);
   localparam logic [3:0]      SEL_LAST = 4'(NUM_SEL - 1);

   if ((DIGIT_PERIOD < 2) || (NUM_SEL < 1) || (NUM_SEL > 16) || (DEBOUNCE_CYCLES < 1)) begin : g_bad_cfg
      $error("ssd_scan_controller: unsupported parameter set");
   end

   logic             btn_meta_q, btn_sync_q, btn_prev_q;
   logic             btn_lvl_s, press_s;
   logic [3:0]       sel_q, sel_d;
   logic             sel_chg_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic             term_s, wrap_s;
   logic [15:0]      disp_q, disp_d;
   logic [3:0]       anode_q, anode_d;
   logic [6:0]       cathode_q, cathode_d;
   logic [3:0]       digit_s;
   logic             blank_s;
   logic [15:0]      bcd_s;
   logic             done_s, busy_s;

   // Two-flop synchronizer and edge-detect history for the raw button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         btn_prev_q <= 1'b0;
      end else begin
         btn_meta_q <= btn_next;
         btn_sync_q <= btn_meta_q;
         btn_prev_q <= btn_lvl_s;
      end
   end

`ifdef SSD_DEBOUNCE_EN
   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            btn_db_q, btn_db_d;

   // Debounced level and its stability counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_q <= {DB_W{1'b0}};
         btn_db_q <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         btn_db_q <= btn_db_d;
      end
   end

   // A differing level must persist DEBOUNCE_CYCLES cycles to be accepted.
   always_comb begin
      db_cnt_d = db_cnt_q;
      btn_db_d = btn_db_q;
      if (btn_sync_q != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_sync_q;
            db_cnt_d = {DB_W{1'b0}};
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end else begin
         db_cnt_d = {DB_W{1'b0}};
      end
   end

   assign btn_lvl_s = btn_db_q;
`else
   assign btn_lvl_s = btn_sync_q;
`endif

   assign press_s = btn_lvl_s & ~btn_prev_q;

   // Selection code advance with wrap at NUM_SEL-1.
   always_comb begin
      sel_d = sel_q;
      if (press_s) begin
         if (sel_q >= SEL_LAST) begin
            sel_d = 4'd0;
         end else begin
            sel_d = sel_q + 4'd1;
         end
      end else begin
         sel_d = sel_q;
      end
   end

   // Selection register; sel_chg_q marks the cycle the new code is visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= 4'd0;
         sel_chg_q <= 1'b0;
      end else begin
         sel_q     <= sel_d;
         sel_chg_q <= press_s;
      end
   end

   ssd_bin2bcd u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (wrap_s),
      .abort_i (sel_chg_q),
      .value_i (ssd_value),
      .bcd_o   (bcd_s),
      .done_o  (done_s),
      .busy_o  (busy_s)
   );

   assign term_s = (div_q == DIV_LAST);
   assign wrap_s = term_s & (idx_q == 2'd3);

   // Digit to show after the terminal count, plus leading-zero blanking.
   always_comb begin
      digit_s = disp_q[3:0];
      blank_s = 1'b0;
      case (idx_d)
         2'd0: begin
            digit_s = disp_q[3:0];
            blank_s = 1'b0;
         end
         2'd1: begin
            digit_s = disp_q[7:4];
            blank_s = (disp_q[15:4] == 12'd0);
         end
         2'd2: begin
            digit_s = disp_q[11:8];
            blank_s = (disp_q[15:8] == 8'd0);
         end
         2'd3: begin
            digit_s = disp_q[15:12];
            blank_s = (disp_q[15:12] == 4'd0);
         end
         default: begin
            digit_s = disp_q[3:0];
            blank_s = 1'b0;
         end
      endcase
   end

   // Scan divider, digit index, display register and segment outputs.
   always_comb begin
      div_d     = div_q;
      idx_d     = idx_q;
      anode_d   = anode_q;
      cathode_d = cathode_q;
      if (done_s) begin
         disp_d = bcd_s;
      end else begin
         disp_d = disp_q;
      end
      if (term_s) begin
         div_d = {DIV_W{1'b0}};
         idx_d = idx_q + 2'd1;
      end else begin
         div_d = div_q + DIV_W'(1);
         idx_d = idx_q;
      end
      if (term_s) begin
         anode_d   = ~(4'b0001 << idx_d);
         cathode_d = blank_s ? SEG_BLANK : seg_decode(digit_s);
      end else begin
         anode_d   = anode_q;
         cathode_d = cathode_q;
      end
   end

   // Scan and display registers; outputs blank in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q     <= {DIV_W{1'b0}};
         idx_q     <= 2'd0;
         disp_q    <= 16'd0;
         anode_q   <= 4'b1111;
         cathode_q <= SEG_BLANK;
      end else begin
         div_q     <= div_d;
         idx_q     <= idx_d;
         disp_q    <= disp_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
      end
   end

   assign ssd_sel = sel_q;
   assign anode   = anode_q;
   assign cathode = cathode_q;
   assign busy    = busy_s;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_controller
// Directed bench for ssd_scan_controller with DIGIT_PERIOD=4, NUM_SEL=11,
// DEBOUNCE_CYCLES=4. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ssd_scan_controller;

   localparam int DP  = 4;
   localparam int DBC = 4;
   localparam int NS  = 11;

`ifdef SSD_DEBOUNCE_EN
   localparam int ABORT_BUSY_LEN = 24;
`else
   localparam int ABORT_BUSY_LEN = 20;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn_next;
   logic [12:0] ssd_value;
   logic [3:0]  ssd_sel;
   logic [3:0]  anode;
   logic [6:0]  cathode;
   logic        busy;

   logic        use_lut;
   logic [12:0] val_tb;
   int          n_checks = 0;
   int          n_fails  = 0;

   always #5 clk = ~clk;

   // Models the combinational debug selector: value depends on ssd_sel.
   always_comb begin
      if (use_lut) begin
         ssd_value = 13'(ssd_sel) * 13'd500 + 13'd123;
      end else begin
         ssd_value = val_tb;
      end
   end

   ssd_scan_controller #(
      .DIGIT_PERIOD    (DP),
      .DEBOUNCE_CYCLES (DBC),
      .NUM_SEL         (NS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_next  (btn_next),
      .ssd_value (ssd_value),
      .ssd_sel   (ssd_sel),
      .anode     (anode),
      .cathode   (cathode),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_digit(input int k, input logic [6:0] exp, input string tag);
      logic [3:0] an_exp;
      int n;
      an_exp = ~(4'b0001 << k);
      n = 0;
      while (anode !== an_exp && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_anode"}, {12'd0, anode}, {12'd0, an_exp});
      chk(tag, {9'd0, cathode}, {9'd0, exp});
   endtask

   task automatic check_frame(input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3,
                              input string tag);
      check_digit(0, c0, {tag, "_d0"});
      check_digit(1, c1, {tag, "_d1"});
      check_digit(2, c2, {tag, "_d2"});
      check_digit(3, c3, {tag, "_d3"});
   endtask

   task automatic wait_busy(input logic lvl, input string tag);
      int n;
      n = 0;
      while (busy !== lvl && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {15'd0, busy}, {15'd0, lvl});
   endtask

   task automatic press(input int hold, input int rel);
      btn_next = 1'b1;
      cycles(hold);
      btn_next = 1'b0;
      cycles(rel);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      logic [3:0] an_seq [5];
      an_seq[0] = 4'b1110;
      an_seq[1] = 4'b1101;
      an_seq[2] = 4'b1011;
      an_seq[3] = 4'b0111;
      an_seq[4] = 4'b1110;

      rst_n    = 1'b0;
      btn_next = 1'b0;
      use_lut  = 1'b0;
      val_tb   = 13'd1234;
      cycles(3);
      chk("rst_anode",   {12'd0, anode},   16'h000F);
      chk("rst_cathode", {9'd0, cathode},  16'h007F);
      chk("rst_sel",     {12'd0, ssd_sel}, 16'h0000);
      chk("rst_busy",    {15'd0, busy},    16'h0000);

      rst_n = 1'b1;
      wait_busy(1'b1, "busy_after_release");
      cycles(60);
      check_frame(7'h19, 7'h30, 7'h24, 7'h79, "v1234");

      val_tb = 13'd8191;
      cycles(60);
      check_frame(7'h79, 7'h10, 7'h79, 7'h00, "v8191");

      val_tb = 13'd0;
      cycles(60);
      check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, "v0");

      val_tb = 13'd7;
      cycles(60);
      check_frame(7'h78, 7'h7F, 7'h7F, 7'h7F, "v7");

      val_tb = 13'd1005;
      cycles(60);
      check_frame(7'h12, 7'h40, 7'h40, 7'h79, "v1005");

      // Anode scan order, 4 clocks per digit.
      cnt = 0;
      while (anode === 4'b1110 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      cnt = 0;
      while (anode !== 4'b1110 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("scan_start", {12'd0, anode}, {12'd0, an_seq[0]});
      cycles(3);
      chk("scan_hold", {12'd0, anode}, {12'd0, an_seq[0]});
      cycles(1);
      for (int s = 1; s < 5; s++) begin
         chk($sformatf("scan_step%0d", s), {12'd0, anode}, {12'd0, an_seq[s]});
         cycles(4);
      end

      // Uninterrupted conversion: 13 SHIFT cycles + DONE with busy high.
      wait_busy(1'b0, "busy_low_sync");
      wait_busy(1'b1, "busy_high_sync");
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("busy_len", 16'(cnt), 16'd14);

      // Selection stepping with wrap.
      use_lut = 1'b1;
      for (int i = 0; i < NS; i++) begin
         press(8, 8);
         chk($sformatf("sel_step%0d", i), {12'd0, ssd_sel}, 16'((i + 1) % NS));
      end
      cycles(60);
      check_frame(7'h30, 7'h24, 7'h79, 7'h7F, "lut_sel0");

      // Selection change in SHIFT cycle 5 restarts the conversion.
      wait_busy(1'b0, "abort_low_sync");
      wait_busy(1'b1, "abort_high_sync");
      cnt = 1;
      @(negedge clk);
      btn_next = 1'b1;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      btn_next = 1'b0;
      chk("abort_busy_len", 16'(cnt), 16'(ABORT_BUSY_LEN));
      cycles(10);
      chk("abort_sel", {12'd0, ssd_sel}, 16'd1);
      cycles(60);
      check_frame(7'h30, 7'h24, 7'h02, 7'h7F, "lut_sel1");

`ifdef SSD_DEBOUNCE_EN
      press(2, 12);
      chk("db_glitch", {12'd0, ssd_sel}, 16'd1);
      press(6, 12);
      chk("db_hold", {12'd0, ssd_sel}, 16'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
